// File: rtl/ps2_keycode_rollover.sv
// PS/2 keyboard receiver with a four-slot key rollover table.
// Frames are sampled on synchronized PS2_CLK falling edges; a watchdog abandons stalled frames.
//
// state    | meaning
// S_IDLE   | waiting for a start bit (data 0 on a falling edge)
// S_DATA   | shifting in 8 data bits, LSB first
// S_PARITY | capturing the parity bit
// S_STOP   | capturing the stop bit, frame completes here
module ps2_keycode_rollover #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        PS2_CLK,
  input  logic        PS2_DAT,
  output logic [31:0] PS2keycode,
  output logic [7:0]  rx_byte,
  output logic        byte_valid,
  output logic        frame_err
);

  localparam int              WD_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic            r_clk_s1, r_clk_s2, r_clk_prev;
  logic            r_dat_s1, r_dat_s2;
  logic [2:0]      r_bit_cnt;
  logic [WD_W-1:0] r_wdog;
  logic [7:0]      r_shift;
  logic            r_parity;
  logic [7:0]      r_rx_byte;
  logic            r_byte_valid;
  logic            r_frame_err;
  logic [3:0][7:0] r_keys;
  logic            r_ext;
  logic            r_brk;

  logic            w_fall;
  logic            w_timeout;
  logic            w_frame_done;
  logic            w_good;
  logic            w_bad;
  logic            w_hit;
  logic            w_has_empty;
  logic [1:0]      w_empty_idx;

  // Synchronizers reset to the PS/2 idle level so release never looks like an edge.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_clk_s1   <= 1'b1;
      r_clk_s2   <= 1'b1;
      r_clk_prev <= 1'b1;
      r_dat_s1   <= 1'b1;
      r_dat_s2   <= 1'b1;
    end else begin
      r_clk_s1   <= PS2_CLK;
      r_clk_s2   <= r_clk_s1;
      r_clk_prev <= r_clk_s2;
      r_dat_s1   <= PS2_DAT;
      r_dat_s2   <= r_dat_s1;
    end
  end

  assign w_fall    = r_clk_prev & ~r_clk_s2;
  assign w_timeout = (r_state != S_IDLE) && !w_fall && (r_wdog == WD_LAST);

  always_ff @(posedge Clk) begin
    if (Reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_frame_done = 1'b0;
    if (w_timeout) begin
      w_state_next = S_IDLE;
    end else if (w_fall) begin
      case (r_state)
        S_IDLE:   if (!r_dat_s2) w_state_next = S_DATA;
        S_DATA:   if (r_bit_cnt == 3'd7) w_state_next = S_PARITY;
        S_PARITY: w_state_next = S_STOP;
        S_STOP: begin
          w_state_next = S_IDLE;
          w_frame_done = 1'b1;
        end
        default:  w_state_next = S_IDLE;
      endcase
    end
  end

  assign w_good = w_frame_done && r_dat_s2 && (^{r_shift, r_parity});
  assign w_bad  = w_frame_done && !w_good;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_bit_cnt    <= '0;
      r_wdog       <= '0;
      r_shift      <= '0;
      r_parity     <= 1'b0;
      r_rx_byte    <= '0;
      r_byte_valid <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_byte_valid <= w_good;
      r_frame_err  <= w_bad;
      if (w_good) r_rx_byte <= r_shift;

      if (w_fall || w_timeout || r_state == S_IDLE) r_wdog <= '0;
      else                                          r_wdog <= r_wdog + 1'b1;

      if (w_fall && !w_timeout) begin
        case (r_state)
          S_IDLE:   r_bit_cnt <= '0;
          S_DATA: begin
            r_shift   <= {r_dat_s2, r_shift[7:1]};
            r_bit_cnt <= r_bit_cnt + 3'd1;
          end
          S_PARITY: r_parity <= r_dat_s2;
          default:  ;
        endcase
      end
    end
  end

  // Slot lookup: scan high to low so the lowest empty index wins.
  always_comb begin
    w_hit       = 1'b0;
    w_has_empty = 1'b0;
    w_empty_idx = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (r_keys[k] == r_rx_byte) w_hit = 1'b1;
      if (r_keys[k] == 8'h00) begin
        w_has_empty = 1'b1;
        w_empty_idx = 2'(k);
      end
    end
  end

  // Extended codes share the table with their base byte; ext only marks the prefix.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_keys <= '0;
      r_ext  <= 1'b0;
      r_brk  <= 1'b0;
    end else if (r_frame_err) begin
      r_ext <= 1'b0;
      r_brk <= 1'b0;
    end else if (r_byte_valid) begin
      case (r_rx_byte)
        8'hE0: r_ext <= 1'b1;
        8'hF0: r_brk <= 1'b1;
        8'hE1, 8'h00, 8'hFF: begin
          r_ext <= r_ext;
          r_brk <= r_brk;
        end
        default: begin
          r_ext <= 1'b0;
          r_brk <= 1'b0;
          if (r_brk) begin
            for (int k = 0; k < 4; k++)
              if (r_keys[k] == r_rx_byte) r_keys[k] <= 8'h00;
          end else if (!w_hit && w_has_empty) begin
            r_keys[w_empty_idx] <= r_rx_byte;
          end
        end
      endcase
    end
  end

  assign PS2keycode = r_keys;
  assign rx_byte    = r_rx_byte;
  assign byte_valid = r_byte_valid;
  assign frame_err  = r_frame_err;

endmodule

// File: tb/tb_ps2_keycode_rollover.sv
// Bench for ps2_keycode_rollover: directed scenarios plus random byte streams checked
// against a slot-table reference model.
module tb_ps2_keycode_rollover;

  localparam int TO = 200;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        PS2_CLK = 1'b1;
  logic        PS2_DAT = 1'b1;
  logic [31:0] PS2keycode;
  logic [7:0]  rx_byte;
  logic        byte_valid;
  logic        frame_err;

  int n_checks = 0;
  int n_fail   = 0;
  int n_valid  = 0;
  int n_err    = 0;

  logic [7:0] m_tab [4];
  logic       m_brk;
  logic [7:0] m_rx;

  ps2_keycode_rollover #(.TIMEOUT_CYCLES(TO)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .PS2_CLK    (PS2_CLK),
    .PS2_DAT    (PS2_DAT),
    .PS2keycode (PS2keycode),
    .rx_byte    (rx_byte),
    .byte_valid (byte_valid),
    .frame_err  (frame_err)
  );

  always #5 Clk = ~Clk;

  always @(negedge Clk) begin
    if (byte_valid) n_valid++;
    if (frame_err)  n_err++;
  end

  initial begin
    #1_500_000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h want %08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_pack();
    return {m_tab[3], m_tab[2], m_tab[1], m_tab[0]};
  endfunction

  task automatic m_clear();
    for (int i = 0; i < 4; i++) m_tab[i] = 8'h00;
    m_brk = 1'b0;
    m_rx  = 8'h00;
  endtask

  task automatic m_byte(input logic [7:0] b);
    bit present;
    bit placed;
    if (b == 8'hF0) begin
      m_brk = 1'b1;
    end else if (b == 8'hE0 || b == 8'hE1 || b == 8'h00 || b == 8'hFF) begin
      // prefixes and ignored bytes leave the table alone
    end else begin
      if (m_brk) begin
        for (int i = 0; i < 4; i++) if (m_tab[i] == b) m_tab[i] = 8'h00;
      end else begin
        present = 0;
        foreach (m_tab[i]) if (m_tab[i] == b) present = 1;
        placed = present;
        for (int i = 0; i < 4; i++)
          if (!placed && m_tab[i] == 8'h00) begin
            m_tab[i] = b;
            placed = 1;
          end
      end
      m_brk = 1'b0;
    end
  endtask

  task automatic send_bit(input logic b);
    PS2_DAT = b;
    repeat (4) @(negedge Clk);
    PS2_CLK = 1'b0;
    repeat (8) @(negedge Clk);
    PS2_CLK = 1'b1;
    repeat (4) @(negedge Clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad);
    logic        par;
    logic [31:0] kc_old;
    logic [31:0] kc_new;
    int          nv0;
    int          ne0;
    par    = ~(^b) ^ bad;
    kc_old = m_pack();
    nv0    = n_valid;
    ne0    = n_err;
    if (!bad) begin
      m_byte(b);
      m_rx = b;
    end else begin
      m_brk = 1'b0;
    end
    kc_new = m_pack();
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(par);
    PS2_DAT = 1'b1;
    repeat (4) @(negedge Clk);
    PS2_CLK = 1'b0;
    repeat (3) @(negedge Clk);
    check_eq("byte_valid_e1", 32'(byte_valid), 32'(!bad));
    check_eq("frame_err_e1", 32'(frame_err), 32'(bad));
    check_eq("rx_byte_e1", 32'(rx_byte), 32'(m_rx));
    check_eq("keycode_e1", PS2keycode, kc_old);
    @(negedge Clk);
    check_eq("keycode_e2", PS2keycode, kc_new);
    check_eq("byte_valid_e2", 32'(byte_valid), 32'd0);
    repeat (4) @(negedge Clk);
    PS2_CLK = 1'b1;
    repeat (4) @(negedge Clk);
    check_eq("valid_pulses", 32'(n_valid - nv0), bad ? 32'd0 : 32'd1);
    check_eq("err_pulses", 32'(n_err - ne0), bad ? 32'd1 : 32'd0);
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Reset = 1'b1;
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    m_clear();
    repeat (2) @(negedge Clk);
  endtask

  logic [7:0] pool [16] = '{8'h1C, 8'h1D, 8'h1B, 8'h23, 8'h75, 8'h72, 8'h6B, 8'h74,
                            8'h14, 8'hF0, 8'hF0, 8'hF0, 8'hE0, 8'hE1, 8'h00, 8'hFF};
  logic [7:0] pause_seq [8] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};

  initial begin
    int nv0;
    int ne0;
    logic [7:0] pb;
    m_clear();
    repeat (3) @(negedge Clk);
    check_eq("rst_keycode", PS2keycode, 32'h0);
    check_eq("rst_rx_byte", 32'(rx_byte), 32'h0);
    check_eq("rst_valid", 32'(byte_valid), 32'h0);
    check_eq("rst_err", 32'(frame_err), 32'h0);
    Reset = 1'b0;
    repeat (2) @(negedge Clk);

    send_frame(8'h1C, 0);
    check_eq("single_1C", PS2keycode, 32'h0000001C);

    do_reset();
    send_frame(8'h1D, 0); send_frame(8'h1C, 0); send_frame(8'h1B, 0);
    send_frame(8'h23, 0); send_frame(8'h75, 0);
    check_eq("full_table", PS2keycode, 32'h231B1C1D);
    send_frame(8'hF0, 0); send_frame(8'h1C, 0);
    check_eq("break_hole", PS2keycode, 32'h231B001D);
    send_frame(8'h75, 0);
    check_eq("fill_hole", PS2keycode, 32'h231B751D);

    do_reset();
    send_frame(8'hE0, 0); send_frame(8'h75, 0);
    send_frame(8'hE0, 0); send_frame(8'h75, 0);
    check_eq("ext_repeat", PS2keycode, 32'h00000075);
    send_frame(8'hE0, 0); send_frame(8'hF0, 0); send_frame(8'h75, 0);
    check_eq("ext_break", PS2keycode, 32'h0);

    send_frame(8'h1C, 1);
    check_eq("bad_parity_kc", PS2keycode, 32'h0);
    send_frame(8'h1C, 0);
    check_eq("after_bad", PS2keycode, 32'h0000001C);

    // a stray break prefix then a bad frame must not turn the next make into a break
    send_frame(8'hF0, 0); send_frame(8'h23, 1); send_frame(8'h23, 0);
    check_eq("flags_cleared", PS2keycode, 32'h0000231C);

    do_reset();
    nv0 = n_valid;
    ne0 = n_err;
    pb  = 8'h5A;
    send_bit(1'b0);
    for (int i = 0; i < 5; i++) send_bit(pb[i]);
    repeat (TO + 20) @(negedge Clk);
    check_eq("timeout_no_err", 32'(n_err - ne0), 32'd0);
    check_eq("timeout_no_valid", 32'(n_valid - nv0), 32'd0);
    send_frame(8'h23, 0);
    check_eq("after_timeout", PS2keycode, 32'h00000023);

    do_reset();
    send_frame(8'h1D, 0);
    check_eq("pre_reset_kc", PS2keycode, 32'h0000001D);
    nv0 = n_valid;
    ne0 = n_err;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b0);
    Reset = 1'b1;
    @(negedge Clk);
    check_eq("midrst_keycode", PS2keycode, 32'h0);
    check_eq("midrst_rx_byte", 32'(rx_byte), 32'h0);
    check_eq("midrst_valid", 32'(byte_valid), 32'h0);
    check_eq("midrst_err", 32'(frame_err), 32'h0);
    Reset = 1'b0;
    m_clear();
    for (int i = 0; i < 6; i++) send_bit(1'b1);
    repeat (4) @(negedge Clk);
    check_eq("remainder_dropped", PS2keycode, 32'h0);
    check_eq("remainder_no_valid", 32'(n_valid - nv0), 32'd0);
    check_eq("remainder_no_err", 32'(n_err - ne0), 32'd0);
    send_frame(8'h1C, 0);
    check_eq("post_rst_store", PS2keycode, 32'h0000001C);

    foreach (pause_seq[i]) send_frame(pause_seq[i], 0);
    check_eq("pause_nets_zero", PS2keycode, 32'h0000001C);

    for (int n = 0; n < 120; n++)
      send_frame(pool[$urandom_range(0, 15)], ($urandom_range(0, 9) == 0));
    check_eq("random_final", PS2keycode, m_pack());

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
